multiplier_control: RTL

Control unit for the 32-bit sequential shift-add multiplier datapath. It accepts a start request from the ALU and loads operands into the datapath. It then steps the datapath through 32 test/add/shift iterations using the datapath's `write` (product LSB) and `less32` status, and reports completion or timeout. It sits directly upstream of the datapath, driving its `rst`/`shr`/`add`/`incr` inputs.

---
 rtl/multiplier_control.sv | 93 +++++++++
 1 files changed

// File: rtl/multiplier_control.sv
// Sequencer for the 32-bit shift-add multiplier datapath: loads the operands,
// runs 32 test/add/shift iterations, and flags completion or a cycle-budget timeout.
module multiplier_control #(
  parameter int CYCLE_W = 7,
  parameter int TIMEOUT = 100
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               write,
  input  logic               less32,
  output logic               load,
  output logic               add,
  output logic               shr,
  output logic               incr,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [CYCLE_W-1:0] cycles,
  output logic [6:0]         state_dbg
);

  localparam logic [6:0] S_IDLE  = 7'b000_0001;
  localparam logic [6:0] S_LOAD  = 7'b000_0010;
  localparam logic [6:0] S_TEST  = 7'b000_0100;
  localparam logic [6:0] S_ADD   = 7'b000_1000;
  localparam logic [6:0] S_SHIFT = 7'b001_0000;
  localparam logic [6:0] S_DONE  = 7'b010_0000;
  localparam logic [6:0] S_ERR   = 7'b100_0000;

  localparam logic [CYCLE_W-1:0] CYC_MAX   = {CYCLE_W{1'b1}};
  localparam logic [CYCLE_W-1:0] CYC_ONE   = CYCLE_W'(1);
  localparam logic [CYCLE_W-1:0] TIMEOUT_C = CYCLE_W'(TIMEOUT);

  logic [6:0]         state_q, state_d;
  logic [CYCLE_W-1:0] cycles_q, cycles_d;
  logic [CYCLE_W-1:0] cycles_inc;
  logic               active;

  assign active     = |(state_q & (S_LOAD | S_TEST | S_ADD | S_SHIFT));
  assign cycles_inc = (cycles_q == CYC_MAX) ? cycles_q : cycles_q + CYC_ONE;

  always_comb begin
    state_d  = state_q;
    cycles_d = cycles_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d  = S_LOAD;
          cycles_d = '0;
        end
      end
      S_LOAD:  state_d = S_TEST;
      S_TEST: begin
        if (!less32)    state_d = S_DONE;
        else if (write) state_d = S_ADD;
        else            state_d = S_SHIFT;
      end
      S_ADD:   state_d = S_SHIFT;
      S_SHIFT: state_d = S_TEST;
      S_DONE:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // A finishing TEST beats a coincident timeout: the result is already valid.
    if (active) begin
      cycles_d = cycles_inc;
      if ((cycles_inc == TIMEOUT_C) && (state_d != S_DONE)) state_d = S_ERR;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      cycles_q <= '0;
    end else begin
      state_q  <= state_d;
      cycles_q <= cycles_d;
    end
  end

  // Straight decodes of one-hot flop bits so load (an async datapath input) cannot glitch.
  assign load      = state_q[1];
  assign add       = state_q[3];
  assign shr       = state_q[4];
  assign incr      = state_q[4];
  assign busy      = |state_q[4:1];
  assign done      = state_q[5];
  assign err       = state_q[6];
  assign cycles    = cycles_q;
  assign state_dbg = state_q;

endmodule
